// File: rtl/vmu_load_issue_pkg.sv
// rtl/vmu_load_issue_pkg.sv - shared VMU constants, command layout and state encoding
package vmu_load_issue_pkg;

  localparam int VLEN_W_DEF   = 11;
  localparam int TAG_W_DEF    = 8;
  localparam int BASE_LSB     = 0;
  localparam int STRIDE_LSB   = 32;
  localparam int VLEN_LSB     = 64;
  localparam int SZ_LSB       = 64 + VLEN_W_DEF;
  localparam int VM_ISCMD_SZ  = 2 + VLEN_W_DEF + 64;
  localparam int LINE_OFF_W   = 4;
  localparam int LINE_W       = 32 - LINE_OFF_W;
  localparam int LRQ_W        = LINE_W + TAG_W_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] addr);
    return addr[31:LINE_OFF_W];
  endfunction

  function automatic logic [31:0] align_mask(input logic [1:0] sz);
    return (32'd1 << sz) - 32'd1;
  endfunction

endpackage

// File: rtl/vmu_load_issue.sv
// rtl/vmu_load_issue.sv - vector-load issue: walks element addresses, one D$ line request per distinct line
module vmu_load_issue
  import vmu_load_issue_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int VLEN_W = VLEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2+VLEN_W+64-1:0]    iscmdq_deq_bits,
  input  logic                      iscmdq_deq_val,
  output logic                      iscmdq_deq_rdy,
  output logic [LINE_W+TAG_W-1:0]   lrq_enq_bits,
  output logic                      lrq_enq_val,
  input  logic                      lrq_enq_rdy,
  input  logic [TAG_W-1:0]          roq_deq_tag_bits,
  input  logic                      roq_deq_tag_val,
  output logic                      roq_deq_tag_rdy,
  output logic                      busy
);

  localparam int SZ_OFF = (VLEN_W == VLEN_W_DEF) ? SZ_LSB : VLEN_LSB + VLEN_W;

  state_t              state;
  logic [31:0]         cur_addr;
  logic [31:0]         stride;
  logic [VLEN_W-1:0]   remain;
  logic [LINE_W-1:0]   last_line;
  logic                first;

  logic                run;
  logic                need_req;
  logic                fire;
  logic                advance;
  logic [1:0]          cmd_sz;
  logic [31:0]         cmd_base;

  assign run      = (state == ST_RUN);
  assign cmd_sz   = iscmdq_deq_bits[SZ_OFF +: 2];
  assign cmd_base = iscmdq_deq_bits[BASE_LSB +: 32];

  // A request is needed for the first element and whenever the element leaves the previous line.
  assign need_req        = first | (line_of(cur_addr) != last_line);
  assign lrq_enq_val     = run & need_req & roq_deq_tag_val;
  assign roq_deq_tag_rdy = run & need_req & lrq_enq_rdy;
  assign fire            = lrq_enq_val & lrq_enq_rdy;
  assign advance         = run & (~need_req | fire);
  assign lrq_enq_bits    = {line_of(cur_addr), roq_deq_tag_bits};
  assign iscmdq_deq_rdy  = ~run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      first     <= 1'b0;
      remain    <= '0;
      cur_addr  <= '0;
      stride    <= '0;
      last_line <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iscmdq_deq_val) begin
            // Elements are naturally aligned by contract; sz exists only to check that.
            assert ((cmd_base & align_mask(cmd_sz)) == 32'd0);
            cur_addr <= cmd_base;
            stride   <= iscmdq_deq_bits[STRIDE_LSB +: 32];
            remain   <= iscmdq_deq_bits[VLEN_LSB +: VLEN_W];
            first    <= 1'b1;
            state    <= ST_RUN;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (advance) begin
            last_line <= line_of(cur_addr);
            first     <= 1'b0;
            cur_addr  <= cur_addr + stride;
            remain    <= remain - 1'b1;
            if (remain == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmu_load_issue.sv
// tb/tb_vmu_load_issue.sv - randomized and directed bench for vmu_load_issue against a line-walk model
module tb_vmu_load_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [76:0] iscmdq_deq_bits;
  logic        iscmdq_deq_val;
  logic        iscmdq_deq_rdy;
  logic [35:0] lrq_enq_bits;
  logic        lrq_enq_val;
  logic        lrq_enq_rdy;
  logic [7:0]  roq_deq_tag_bits;
  logic        roq_deq_tag_val;
  logic        roq_deq_tag_rdy;
  logic        busy;

  always #5 clk = ~clk;

  vmu_load_issue #(.TAG_W(8), .VLEN_W(11)) dut (
    .clk(clk), .reset(reset),
    .iscmdq_deq_bits(iscmdq_deq_bits), .iscmdq_deq_val(iscmdq_deq_val), .iscmdq_deq_rdy(iscmdq_deq_rdy),
    .lrq_enq_bits(lrq_enq_bits), .lrq_enq_val(lrq_enq_val), .lrq_enq_rdy(lrq_enq_rdy),
    .roq_deq_tag_bits(roq_deq_tag_bits), .roq_deq_tag_val(roq_deq_tag_val), .roq_deq_tag_rdy(roq_deq_tag_rdy),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  next_tag;
  logic [27:0] got_lines[$];
  logic [7:0]  got_tags[$];
  int          got_cyc[$];
  logic [27:0] exp_lines[$];
  int          exp_elem[$];
  int          run_cycles, tags_taken, viol_val, viol_rdy, viol_frozen;
  bit          timeout;
  int          hold_lrq, starve_at, starve_len;
  bit          rand_bp;

  // Reference: enumerate element addresses and keep the first of each run of equal lines.
  task automatic model_cmd(input logic [31:0] base, input logic [31:0] stride, input int vlen);
    logic [31:0] a;
    logic [27:0] prev;
    exp_lines.delete();
    exp_elem.delete();
    prev = '0;
    for (int i = 0; i <= vlen; i++) begin
      a = base + stride * 32'(i);
      if (i == 0 || a[31:4] != prev) begin
        exp_lines.push_back(a[31:4]);
        exp_elem.push_back(i);
      end
      prev = a[31:4];
    end
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [31:0] stride, input int vlen, input logic [1:0] sz);
    int c, w;
    bit pend;
    logic [27:0] pend_line;
    got_lines.delete(); got_tags.delete(); got_cyc.delete();
    tags_taken = 0; viol_val = 0; viol_rdy = 0; viol_frozen = 0; timeout = 0;
    model_cmd(base, stride, vlen);
    @(negedge clk);
    w = 0;
    while (!iscmdq_deq_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    iscmdq_deq_bits = {sz, 11'(vlen), stride, base};
    iscmdq_deq_val  = 1'b1;
    lrq_enq_rdy     = 1'b1;
    roq_deq_tag_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iscmdq_deq_val = 1'b0;
    c = 0;
    pend = 1'b0;
    pend_line = '0;
    while (busy && c < 2000) begin
      lrq_enq_rdy      = (c >= hold_lrq) && (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      roq_deq_tag_val  = !(c >= starve_at && c < starve_at + starve_len) &&
                         (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      roq_deq_tag_bits = next_tag;
      #1;
      if (lrq_enq_val && !roq_deq_tag_val) viol_val++;
      if (roq_deq_tag_rdy && !lrq_enq_rdy) viol_rdy++;
      if (pend && lrq_enq_val && lrq_enq_bits[35:8] != pend_line) viol_frozen++;
      pend      = lrq_enq_val && !lrq_enq_rdy;
      pend_line = lrq_enq_bits[35:8];
      if (lrq_enq_val && lrq_enq_rdy) begin
        got_lines.push_back(lrq_enq_bits[35:8]);
        got_tags.push_back(lrq_enq_bits[7:0]);
        got_cyc.push_back(c);
      end
      if (roq_deq_tag_rdy && roq_deq_tag_val) begin
        tags_taken++;
        next_tag++;
      end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    run_cycles = c;
    timeout = (c >= 2000);
    lrq_enq_rdy = 1'b1;
    roq_deq_tag_val = 1'b1;
    hold_lrq = 0; starve_at = 0; starve_len = 0; rand_bp = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (lrq_enq_val !== 1'b0) begin n_fail++; $display("FAIL reset_lrq_val: got %b expected 0", lrq_enq_val); end
    if (roq_deq_tag_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_tag_rdy: got %b expected 0", roq_deq_tag_rdy); end
    if (iscmdq_deq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy: got %b expected 1", iscmdq_deq_rdy); end
  endtask

  task automatic test_unit_stride();
    next_tag = 8'd0;
    run_cmd(32'h1000, 32'd8, 7, 2'd3);
    n_checks += 3;
    if (timeout) begin n_fail++; $display("FAIL unit_timeout: command never completed"); end
    if (run_cycles !== 8) begin n_fail++; $display("FAIL unit_busy_cycles: got %0d expected 8", run_cycles); end
    if (got_lines.size() !== 4) begin n_fail++; $display("FAIL unit_count: got %0d expected 4", got_lines.size()); end
    for (int i = 0; i < 4 && i < got_lines.size(); i++) begin
      n_checks += 3;
      if (got_lines[i] !== 28'h100 + 28'(i)) begin n_fail++; $display("FAIL unit_line[%0d]: got %0h expected %0h", i, got_lines[i], 28'h100 + 28'(i)); end
      if (got_tags[i] !== 8'(i)) begin n_fail++; $display("FAIL unit_tag[%0d]: got %0d expected %0d", i, got_tags[i], i); end
      if (got_cyc[i] !== 2 * i) begin n_fail++; $display("FAIL unit_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 2 * i); end
    end
  endtask

  task automatic test_strided_words();
    logic [7:0] t0;
    t0 = next_tag;
    run_cmd(32'h2004, 32'h40, 2, 2'd2);
    n_checks += 2;
    if (got_lines.size() !== 3) begin n_fail++; $display("FAIL stride_count: got %0d expected 3", got_lines.size()); end
    if (tags_taken !== 3) begin n_fail++; $display("FAIL stride_tags: got %0d expected 3", tags_taken); end
    for (int i = 0; i < 3 && i < got_lines.size(); i++) begin
      n_checks += 3;
      if (got_lines[i] !== 28'h200 + 28'(4 * i)) begin n_fail++; $display("FAIL stride_line[%0d]: got %0h expected %0h", i, got_lines[i], 28'h200 + 28'(4 * i)); end
      if (got_tags[i] !== t0 + 8'(i)) begin n_fail++; $display("FAIL stride_tag[%0d]: got %0d expected %0d", i, got_tags[i], t0 + 8'(i)); end
      if (got_cyc[i] !== i) begin n_fail++; $display("FAIL stride_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], i); end
    end
  endtask

  task automatic test_zero_stride();
    run_cmd(32'h3000, 32'd0, 15, 2'd2);
    n_checks += 4;
    if (got_lines.size() !== 1) begin n_fail++; $display("FAIL zero_count: got %0d expected 1", got_lines.size()); end
    else if (got_lines[0] !== 28'h300) begin n_fail++; $display("FAIL zero_line: got %0h expected 300", got_lines[0]); end
    if (tags_taken !== 1) begin n_fail++; $display("FAIL zero_tags: got %0d expected 1", tags_taken); end
    if (run_cycles !== 16) begin n_fail++; $display("FAIL zero_run_cycles: got %0d expected 16", run_cycles); end
    if (timeout) begin n_fail++; $display("FAIL zero_timeout: command never completed"); end
  endtask

  task automatic test_neg_stride_backpressure();
    logic [7:0] t0;
    t0 = next_tag;
    hold_lrq = 3;
    run_cmd(32'h1018, 32'hFFFF_FFF8, 3, 2'd3);
    n_checks += 5;
    if (got_lines.size() !== 2) begin n_fail++; $display("FAIL neg_count: got %0d expected 2", got_lines.size()); end
    else begin
      if (got_lines[0] !== 28'h101 || got_lines[1] !== 28'h100) begin
        n_fail++; $display("FAIL neg_lines: got %0h,%0h expected 101,100", got_lines[0], got_lines[1]);
      end
      if (got_cyc[0] !== 3 || got_cyc[1] !== 5) begin
        n_fail++; $display("FAIL neg_cycles: got %0d,%0d expected 3,5", got_cyc[0], got_cyc[1]);
      end
      if (got_tags[0] !== t0 || got_tags[1] !== t0 + 8'd1) begin
        n_fail++; $display("FAIL neg_tags: got %0d,%0d expected %0d,%0d", got_tags[0], got_tags[1], t0, t0 + 8'd1);
      end
    end
    if (viol_rdy !== 0) begin n_fail++; $display("FAIL neg_tag_rdy_in_stall: got %0d cycles expected 0", viol_rdy); end
    if (viol_frozen !== 0) begin n_fail++; $display("FAIL neg_frozen: got %0d changes expected 0", viol_frozen); end
  endtask

  task automatic test_tag_starvation();
    logic [7:0] t0;
    t0 = next_tag;
    starve_at = 2;
    starve_len = 5;
    run_cmd(32'h4000, 32'd16, 7, 2'd2);
    n_checks += 4;
    if (viol_val !== 0) begin n_fail++; $display("FAIL starve_lrq_val: got %0d cycles expected 0", viol_val); end
    if (run_cycles !== 13) begin n_fail++; $display("FAIL starve_run_cycles: got %0d expected 13", run_cycles); end
    if (tags_taken !== 8) begin n_fail++; $display("FAIL starve_tags: got %0d expected 8", tags_taken); end
    if (got_lines.size() !== 8) begin n_fail++; $display("FAIL starve_count: got %0d expected 8", got_lines.size()); end
    for (int i = 0; i < 8 && i < got_lines.size(); i++) begin
      n_checks += 2;
      if (got_lines[i] !== 28'h400 + 28'(i)) begin n_fail++; $display("FAIL starve_line[%0d]: got %0h expected %0h", i, got_lines[i], 28'h400 + 28'(i)); end
      if (got_tags[i] !== t0 + 8'(i)) begin n_fail++; $display("FAIL starve_tag[%0d]: got %0d expected %0d", i, got_tags[i], t0 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_command();
    logic [7:0] t0;
    @(negedge clk);
    iscmdq_deq_bits = {2'd0, 11'd7, 32'd16, 32'h5000};
    iscmdq_deq_val  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iscmdq_deq_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      roq_deq_tag_bits = next_tag;
      #1;
      if (roq_deq_tag_rdy && roq_deq_tag_val) next_tag++;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    if (lrq_enq_bits[35:8] !== 28'h503) begin n_fail++; $display("FAIL rst_mid_elem3: got %0h expected 503", lrq_enq_bits[35:8]); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (lrq_enq_val !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lrq_val: got %b expected 0", lrq_enq_val); end
    if (iscmdq_deq_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cmd_rdy: got %b expected 1", iscmdq_deq_rdy); end
    t0 = next_tag;
    run_cmd(32'h0000_0008, 32'd0, 0, 2'd3);
    n_checks += 2;
    if (got_lines.size() !== 1) begin n_fail++; $display("FAIL rst_mid_next_count: got %0d expected 1", got_lines.size()); end
    else if (got_lines[0] !== 28'h0 || got_tags[0] !== t0) begin
      n_fail++; $display("FAIL rst_mid_next_req: got %0h/%0d expected 0/%0d", got_lines[0], got_tags[0], t0);
    end
    if (run_cycles !== 1) begin n_fail++; $display("FAIL rst_mid_next_cycles: got %0d expected 1", run_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz;
    logic [31:0] base, stride;
    logic [7:0]  t0;
    int          vlen, bad;
    for (int k = 0; k < 25; k++) begin
      sz   = 2'($urandom_range(0, 3));
      base = $urandom() & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 4))
        0: stride = 32'd0;
        1: stride = 32'd1 << sz;
        2: stride = -(32'd1 << sz);
        3: stride = 32'd16;
        default: stride = 32'($urandom_range(0, 40)) << sz;
      endcase
      vlen = $urandom_range(0, 12);
      rand_bp = 1'b1;
      t0 = next_tag;
      run_cmd(base, stride, vlen, sz);
      bad = 0;
      if (got_lines.size() != exp_lines.size()) bad = 1;
      else for (int i = 0; i < exp_lines.size(); i++)
        if (got_lines[i] !== exp_lines[i] || got_tags[i] !== t0 + 8'(i)) bad = 1;
      n_checks += 4;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_reqs[%0d]: got %0d reqs expected %0d base %0h stride %0h", k, got_lines.size(), exp_lines.size(), base, stride); end
      if (tags_taken !== exp_lines.size()) begin n_fail++; $display("FAIL b2b_tags[%0d]: got %0d expected %0d", k, tags_taken, exp_lines.size()); end
      if (run_cycles < vlen + 1 || timeout) begin n_fail++; $display("FAIL b2b_run_cycles[%0d]: got %0d expected >= %0d", k, run_cycles, vlen + 1); end
      if (viol_val + viol_rdy + viol_frozen !== 0) begin n_fail++; $display("FAIL b2b_handshake[%0d]: got %0d violations expected 0", k, viol_val + viol_rdy + viol_frozen); end
    end
  endtask

  initial begin
    reset = 1'b1;
    iscmdq_deq_bits = '0;
    iscmdq_deq_val = 1'b0;
    lrq_enq_rdy = 1'b1;
    roq_deq_tag_bits = '0;
    roq_deq_tag_val = 1'b1;
    next_tag = '0;
    hold_lrq = 0; starve_at = 0; starve_len = 0; rand_bp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_unit_stride();
    test_strided_words();
    test_zero_stride();
    test_neg_stride_backpressure();
    test_tag_starvation();
    test_reset_mid_command();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
